// File: rtl/dcfifo_wr_ctrl_pkg.sv
// ============================================================================
// Module  : dcfifo_pkg
// Brief   : Shared constants and Gray/binary helpers for the dual-clock FIFO
//           write and read controllers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dcfifo_pkg;

    localparam int C_ADDR_WIDTH = 5;
    localparam int C_PTR_MAX    = 32;

    function automatic logic [C_PTR_MAX-1:0] bin2gray(input logic [C_PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // MSB-first XOR prefix; zero-extended inputs convert correctly.
    function automatic logic [C_PTR_MAX-1:0] gray2bin(input logic [C_PTR_MAX-1:0] g);
        logic [C_PTR_MAX-1:0] b;
        b[C_PTR_MAX-1] = g[C_PTR_MAX-1];
        for (int i = C_PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : dcfifo_pkg

`default_nettype wire

// File: rtl/dcfifo_wr_ctrl_if.sv
// ============================================================================
// Module  : dcfifo_wr_ctrl_if
// Brief   : Producer / RAM / synchronizer signals of the FIFO write controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface dcfifo_wr_ctrl_if
    import dcfifo_pkg::*;
#(
    parameter int ADDR_WIDTH = C_ADDR_WIDTH
);

    localparam int PW = ADDR_WIDTH + 1;

    logic                  wrreq;
    logic [PW-1:0]         rdptr_gray_sync;
    logic [PW-1:0]         wrptr_gray;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wren;
    logic                  wrfull;
    logic [PW-1:0]         wrusedw;
    logic                  overflow;

    // master: the write controller itself
    modport master (
        input  wrreq, rdptr_gray_sync,
        output wrptr_gray, waddr, wren, wrfull, wrusedw, overflow
    );

    // slave: producer / surrounding FIFO fabric
    modport slave (
        output wrreq, rdptr_gray_sync,
        input  wrptr_gray, waddr, wren, wrfull, wrusedw, overflow
    );

endinterface : dcfifo_wr_ctrl_if

`default_nettype wire

// File: rtl/dcfifo_wr_ctrl_gray2bin.sv
// ============================================================================
// Module  : dcfifo_gray2bin
// Brief   : Combinational Gray-to-binary converter (XOR prefix from the MSB).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dcfifo_gray2bin #(
    parameter int PW = 6
) (
    input  wire logic [PW-1:0] i_gray,
    output logic      [PW-1:0] o_bin
);

    for (genvar i = 0; i < PW; i++) begin : g_prefix
        assign o_bin[i] = ^i_gray[PW-1:i];
    end

endmodule : dcfifo_gray2bin

`default_nettype wire

// File: rtl/dcfifo_wr_ctrl.sv
// ============================================================================
// Module  : dcfifo_wr_ctrl
// Brief   : Write-side pointer controller of a dual-clock FIFO: Gray pointer,
//           registered full flag, fill level and overflow pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dcfifo_wr_ctrl
    import dcfifo_pkg::*;
#(
    parameter int ADDR_WIDTH = C_ADDR_WIDTH
) (
    input  wire logic          clock,
    input  wire logic          reset,
    dcfifo_wr_ctrl_if.master   bus
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wrptr_gray;
    logic [PW-1:0] r_wrusedw;
    logic          r_wrfull;
    logic          r_overflow;

    logic          w_wren;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_full_gray;

    // Accept uses only the registered full flag, keeping rdptr off the wren path.
    assign w_wren      = bus.wrreq & ~r_wrfull;
    assign w_wbin_next = r_wbin + {{(PW-1){1'b0}}, w_wren};
    assign w_gray_next = PW'(bin2gray(C_PTR_MAX'(w_wbin_next)));

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign w_full_gray = {~bus.rdptr_gray_sync[PW-1:PW-2], bus.rdptr_gray_sync[PW-3:0]};

    dcfifo_gray2bin #(
        .PW (PW)
    ) u_rd_gray2bin (
        .i_gray (bus.rdptr_gray_sync),
        .o_bin  (w_rbin)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wbin       <= '0;
            r_wrptr_gray <= '0;
            r_wrfull     <= 1'b0;
            r_wrusedw    <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_wbin       <= w_wbin_next;
            r_wrptr_gray <= w_gray_next;
            r_wrfull     <= (w_gray_next == w_full_gray);
            r_wrusedw    <= w_wbin_next - w_rbin;
            r_overflow   <= bus.wrreq & r_wrfull;
        end
    end

    assign bus.wren       = w_wren;
    assign bus.waddr      = r_wbin[ADDR_WIDTH-1:0];
    assign bus.wrptr_gray = r_wrptr_gray;
    assign bus.wrfull     = r_wrfull;
    assign bus.wrusedw    = r_wrusedw;
    assign bus.overflow   = r_overflow;

endmodule : dcfifo_wr_ctrl

`default_nettype wire

// File: tb/tb_dcfifo_wr_ctrl.sv
// ============================================================================
// Module  : tb_dcfifo_wr_ctrl
// Brief   : Self-checking bench for dcfifo_wr_ctrl against a counter-based
//           reference model (write count, read pointer, occupancy).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcfifo_wr_ctrl;

    localparam int AW    = 5;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int MODV  = 1 << PW;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dcfifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    dcfifo_wr_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pointers as plain integers modulo 2*DEPTH.
    int m_wcnt;
    int m_rd;
    int m_used;
    bit m_full;
    bit m_ovf;
    int n_wren;
    bit seen_wrap;
    logic [PW-1:0] prev_gray;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] to_gray(input int b);
        int g;
        g = b ^ (b >> 1);
        return g[PW-1:0];
    endfunction

    task automatic model_clear();
        m_wcnt = 0; m_rd = 0; m_used = 0; m_full = 0; m_ovf = 0;
    endtask

    task automatic check_outputs();
        chk("wren",     32'(bus.wren),       32'(bus.wrreq && !m_full));
        chk("waddr",    32'(bus.waddr),      32'(m_wcnt % DEPTH));
        chk("gray",     32'(bus.wrptr_gray), 32'(to_gray(m_wcnt)));
        chk("wrfull",   32'(bus.wrfull),     32'(m_full));
        chk("wrusedw",  32'(bus.wrusedw),    32'(m_used));
        chk("overflow", 32'(bus.overflow),   32'(m_ovf));
    endtask

    // One clock: drive inputs, check before the edge, advance model at the edge.
    task automatic cycle(input bit req, input int rd);
        bit acc;
        bus.wrreq           = req;
        bus.rdptr_gray_sync = to_gray(rd);
        @(negedge clock);
        check_outputs();
        if (bus.wren) n_wren++;
        prev_gray = bus.wrptr_gray;
        @(posedge clock);
        acc    = req && !m_full;
        m_ovf  = req && m_full;
        m_wcnt = (m_wcnt + int'(acc)) % MODV;
        m_rd   = rd;
        m_used = (m_wcnt - m_rd + MODV) % MODV;
        m_full = (m_used == DEPTH);
        #1;
        chk("gray_hop", 32'($countones(bus.wrptr_gray ^ prev_gray)), 32'(acc));
        if (prev_gray == 6'b100000 && bus.wrptr_gray == 6'b000000) seen_wrap = 1'b1;
    endtask

    task automatic do_reset();
        bus.wrreq           = 1'b0;
        bus.rdptr_gray_sync = '0;
        reset               = 1'b1;
        #2;
        chk("rst_gray",  32'(bus.wrptr_gray), 32'(0));
        chk("rst_used",  32'(bus.wrusedw),    32'(0));
        chk("rst_full",  32'(bus.wrfull),     32'(0));
        chk("rst_ovf",   32'(bus.overflow),   32'(0));
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        model_clear();
    endtask

    initial begin
        int rd;
        int pr;
        bus.wrreq           = 1'b0;
        bus.rdptr_gray_sync = '0;
        reset               = 1'b1;
        seen_wrap           = 1'b0;
        model_clear();
        do_reset();

        // Fill from empty with the read pointer parked at zero
        n_wren = 0;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 0);
        chk("fill_wren_count", 32'(n_wren),          32'(DEPTH));
        chk("fill_full",       32'(bus.wrfull),      32'(1));
        chk("fill_used",       32'(bus.wrusedw),     32'(32));
        chk("fill_gray",       32'(bus.wrptr_gray),  32'(6'b110000));

        // Keep requesting while full
        n_wren = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 0);
        chk("ovf_no_wren", 32'(n_wren),       32'(0));
        chk("ovf_pulse",   32'(bus.overflow), 32'(1));
        chk("ovf_waddr",   32'(bus.waddr),    32'(0));
        cycle(1'b0, 0);
        chk("ovf_clear",   32'(bus.overflow), 32'(0));

        // One read frees a slot
        cycle(1'b0, 1);
        chk("drain_full", 32'(bus.wrfull),  32'(0));
        chk("drain_used", 32'(bus.wrusedw), 32'(31));
        cycle(1'b1, 1);
        chk("drain_refull", 32'(bus.wrfull), 32'(1));

        // Randomized traffic with varying producer/consumer rates
        for (int ph = 0; ph < 6; ph++) begin
            pr = 20 + ph * 15;
            for (int i = 0; i < 150; i++) begin
                rd = m_rd;
                if (((m_wcnt - m_rd + MODV) % MODV) > 0 && $urandom_range(99) < 100 - pr)
                    rd = (m_rd + 1) % MODV;
                cycle($urandom_range(99) < pr + 10, rd);
            end
        end

        // Streaming with the reader right behind: pointer must wrap cleanly
        do_reset();
        seen_wrap = 1'b0;
        for (int i = 0; i < 70; i++) cycle(1'b1, m_wcnt);
        chk("wrap_seen", 32'(seen_wrap), 32'(1));

        // Asynchronous reset in the middle of a fill
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 0);
        chk("mid_waddr", 32'(bus.waddr), 32'(10));
        bus.wrreq = 1'b0;
        reset     = 1'b1;
        #1;
        chk("mid_rst_gray",  32'(bus.wrptr_gray), 32'(0));
        chk("mid_rst_waddr", 32'(bus.waddr),      32'(0));
        chk("mid_rst_used",  32'(bus.wrusedw),    32'(0));
        chk("mid_rst_full",  32'(bus.wrfull),     32'(0));
        chk("mid_rst_ovf",   32'(bus.overflow),   32'(0));
        chk("mid_rst_wren",  32'(bus.wren),       32'(0));
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dcfifo_wr_ctrl

`default_nettype wire

// File: doc/dcfifo_wr_ctrl.md
DCFIFO_WR_CTRL -- requirements
Module: dcfifo_wr_ctrl

Interface
REQ-001 SHALL provide parameter: ADDR_WIDTH, 5, FIFO address width; depth = 2**ADDR_WIDTH; pointer width PW = ADDR_WIDTH+1.
REQ-002 SHALL provide port: clock  input  1  write-domain clock, all state on rising edge.
REQ-003 SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: wrreq  input  1  write request from producer.
REQ-005 SHALL provide port: rdptr_gray_sync  input  PW  read pointer in Gray code, already synchronized into this clock domain by the dual-clock synchronizer stage.
REQ-006 SHALL provide port: wrptr_gray  output  PW  registered Gray write pointer, fed directly to the read-domain synchronizer's src input.
REQ-007 SHALL provide port: waddr  output  ADDR_WIDTH  RAM write address = low ADDR_WIDTH bits of binary write pointer.
REQ-008 SHALL provide port: wren  output  1  RAM write enable (accepted write).
REQ-009 SHALL provide port: wrfull  output  1  registered full flag.
REQ-010 SHALL provide port: wrusedw  output  PW  registered fill level, 0..2**ADDR_WIDTH.
REQ-011 SHALL provide port: overflow  output  1  one-cycle pulse, write attempted while full.

Function
REQ-012 Accept SHALL be wren = wrreq & ~wrfull, combinational from registered wrfull; no combinational path from rdptr_gray_sync to wren.
REQ-013 Binary pointer wbin (PW bits) SHALL advance by 1 on each accept, wrapping 2**PW-1 -> 0 modulo 2**PW.
REQ-014 wrptr_gray SHALL be registered as wbin_next ^ (wbin_next >> 1), updating on the same edge as wbin; exactly one bit changes per increment, including on wrap.
REQ-015 waddr SHALL equal wbin[ADDR_WIDTH-1:0] (registered pointer), so data presented with wren is written at the current address.
REQ-016 wrfull SHALL be registered as (gray_next == {~rdptr_gray_sync[PW-1:PW-2], rdptr_gray_sync[PW-3:0]}), with gray_next computed from wbin_next; it is therefore recomputed every cycle.
REQ-017 wrusedw SHALL be registered as (wbin_next - gray2bin(rdptr_gray_sync)) mod 2**PW.
REQ-018 Full-cycle boundary: the edge completing the depth-th outstanding write SHALL assert wrfull, with no extra write accepted.
REQ-019 When a read pointer advance arrives, wrfull SHALL deassert, and wrusedw SHALL decrement, one clock after rdptr_gray_sync changes (pessimistic; synchronizer latency is upstream).
REQ-020 Simultaneous accept and rdptr change SHALL produce both effects in the same update (wrusedw unchanged net for +1/-1).
REQ-021 overflow SHALL be registered wrreq & wrfull and SHALL be high for exactly the cycles following each rejected request.
REQ-022 Empty detection SHALL NOT be performed here; it belongs to the read-side controller.

Reset
REQ-023 On reset assertion, asynchronously: wbin=0, wrptr_gray=0, wrfull=0, wrusedw=0, overflow=0; waddr=0; wren therefore 0 regardless of wrreq? No -- wren follows REQ-012 (wrreq & ~0); producers hold wrreq low during reset.
REQ-024 Reset deassertion SHALL need no synchronization inside the block; the system reset synchronizer provides a clean release.
REQ-025 Reset mid-operation SHALL discard all pointer state; pairing read controller is reset by the same system reset.

Structure
REQ-026 Shared package dcfifo_pkg SHALL hold ADDR_WIDTH default and bin2gray/gray2bin functions, used by both write and read controllers.
REQ-027 One sub-module dcfifo_gray2bin (combinational, PW-parameterized XOR prefix) SHALL be instantiated for the rdptr conversion; no other hierarchy.

Verification
REQ-028 Reset: assert reset with wrreq=0 -> wrptr_gray=6'b000000, wrusedw=0, wrfull=0, overflow=0.
REQ-029 Fill: rdptr_gray_sync=0, wrreq=1 for 32 cycles -> 32 wren pulses, waddr 0..31, wrfull=1 and wrusedw=32 after 32nd edge, wrptr_gray=6'b110000.
REQ-030 Overflow: continue wrreq=1 while full for 3 cycles -> wren=0, wbin unchanged, overflow high 3 cycles (one-cycle lag).
REQ-031 Drain release: full, set rdptr_gray_sync=6'b000001 -> next edge wrfull=0, wrusedw=31; next write accepted at waddr=0.
REQ-032 Wrap: stream 64 writes with read pointer tracking -> wbin 63 -> 0, wrptr_gray 6'b100000 -> 6'b000000, every step exactly one Gray bit changes.
REQ-033 Reset mid-fill: after 10 writes assert reset -> all outputs 0 immediately (before next clock edge).
